// File: rtl/store_buffer.sv
// In-order store queue: accepts stores from issue, retires one per cycle to data memory,
// and forwards the youngest matching store's data to the load currently accessing memory.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            StoreValid,
    input  logic [31:0]     StoreA,
    input  logic [31:0]     StoreWD,
    output logic            StoreReady,
    output logic [31:0]     DataMem_WA,
    output logic [31:0]     DataMem_WD,
    output logic            DataMem_WE,
    input  logic            DataMem_Busy,
    input  logic [31:0]     LoadA,
    output logic            LoadHit,
    output logic [31:0]     LoadData,
    output logic            Empty,
    output logic [PTRW:0]   Count
);

    logic [DEPTH-1:0] validQ;
    logic [31:0]      addrQ [DEPTH];
    logic [31:0]      dataQ [DEPTH];
    logic [PTRW-1:0]  headPtr;
    logic [PTRW-1:0]  tailPtr;
    logic [PTRW:0]    entryCount;

    logic enqueue;
    logic retire;
    logic fwdHit;
    logic [31:0] fwdData;

    // Readiness ignores a same-cycle retire, so a full queue always refuses.
    assign StoreReady = (entryCount != (PTRW+1)'(DEPTH));
    assign Empty      = (entryCount == '0);
    assign Count      = entryCount;
    assign DataMem_WE = ~Empty;
    assign DataMem_WA = Empty ? 32'd0 : addrQ[headPtr];
    assign DataMem_WD = Empty ? 32'd0 : dataQ[headPtr];

    assign enqueue = StoreValid & StoreReady;
    assign retire  = DataMem_WE & ~DataMem_Busy;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            entryCount <= '0;
            validQ     <= '0;
        end else begin
            if (enqueue) begin
                validQ[tailPtr] <= 1'b1;
                tailPtr         <= tailPtr + PTRW'(1);
            end
            if (retire) begin
                validQ[headPtr] <= 1'b0;
                headPtr         <= headPtr + PTRW'(1);
            end
            case ({enqueue, retire})
                2'b10:   entryCount <= entryCount + (PTRW+1)'(1);
                2'b01:   entryCount <= entryCount - (PTRW+1)'(1);
                default: entryCount <= entryCount;
            endcase
        end
    end

    // Payload storage needs no reset; the valid bits and counters gate every use of it.
    always_ff @(posedge CLK) begin
        if (enqueue) begin
            addrQ[tailPtr] <= StoreA;
            dataQ[tailPtr] <= StoreWD;
        end
    end

    // Walk oldest to youngest so the last match found is the youngest store.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (validQ[headPtr + PTRW'(i)] && (addrQ[headPtr + PTRW'(i)] == LoadA)) begin
                fwdHit  = 1'b1;
                fwdData = dataQ[headPtr + PTRW'(i)];
            end
        end
    end

    assign LoadHit  = fwdHit;
    assign LoadData = fwdData;

endmodule

// File: doc/store_buffer.md
# store_buffer

Store-side counterpart of the load unit. It accepts store operations from the issue stage, holds them in an in-order queue, and retires them one per cycle to the data-memory write port. Every queued store is checked against the address of an in-flight load, and the youngest matching store's data is forwarded so that loads never read stale memory. It sits between the issue/execute stage and data memory, alongside the load unit.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2
- PTRW, 2, log2(DEPTH)

Ports:
- CLK  in  1  single clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- StoreValid  in  1  issue presents a store this cycle
- StoreA  in  32  store byte address (word-aligned, compared on all 32 bits)
- StoreWD  in  32  store data
- StoreReady  out  1  queue can accept a store this cycle
- DataMem_WA  out  32  write address to data memory
- DataMem_WD  out  32  write data to data memory
- DataMem_WE  out  1  write request to data memory
- DataMem_Busy  in  1  data memory cannot accept a write this cycle
- LoadA  in  32  address of the load currently accessing memory
- LoadHit  out  1  a queued store matches LoadA
- LoadData  out  32  forwarded store data when LoadHit is high, otherwise 0
- Empty  out  1  no stores pending
- Count  out  PTRW+1  number of occupied entries

## Operation
- Storage: circular queue of DEPTH entries. Each entry holds {valid, addr[31:0], data[31:0]}. A head pointer (oldest entry) and a tail pointer (next free slot), each PTRW bits, wrap modulo DEPTH. Count is a separate (PTRW+1)-bit counter.
- Enqueue: when StoreValid && StoreReady, write {1, StoreA, StoreWD} at the tail and advance the tail. If StoreValid is high while StoreReady is low, the store is not taken; the issue stage must hold it.
- StoreReady = (Count != DEPTH). It does not account for a retire in the same cycle, so a full queue refuses the store even when the head retires that cycle.
- Retire: DataMem_WE = ~Empty. DataMem_WA and DataMem_WD show the head entry's addr and data while non-empty, and 0 while empty. The head retires on an edge where DataMem_WE && ~DataMem_Busy: its valid bit clears and the head advances.
- Count update: +1 on enqueue only, -1 on retire only, unchanged when both or neither occur. Empty = (Count == 0).
- Forwarding is combinational. Each valid entry's addr is compared with LoadA. If any entry matches, LoadHit = 1 and LoadData is the data of the youngest match, i.e. the match closest to the tail in program order. Otherwise LoadHit = 0 and LoadData = 0.
- The head entry still forwards during the cycle it retires.
- A store being enqueued in the current cycle is not visible to forwarding until the next cycle.
- Stores are never reordered or merged. Two stores to the same address both retire, in order.

## Timing
- Reset state: head = tail = 0, Count = 0, all valid bits = 0. Resulting outputs: StoreReady = 1, DataMem_WE = 0, DataMem_WA = 0, DataMem_WD = 0, LoadHit = 0, LoadData = 0, Empty = 1.
- Reset asserted mid-operation discards all pending stores with no memory write. Reset takes priority over a simultaneous enqueue or retire.
- Latency: a store accepted at edge k drives DataMem_WE in the cycle after edge k if the queue was empty, so the minimum latency is 1 cycle. The write completes at edge k+1 if Busy is low.
- Throughput: one enqueue and one retire per cycle.
- DataMem_Busy stalls the head indefinitely. While stalled, WA/WD/WE stay stable and enqueues continue until the queue is full.
- Wrap-around: pointers roll over from DEPTH-1 to 0 with no bubble.
- Full with retire and StoreValid in the same cycle: the retire happens, the enqueue is refused, and StoreReady goes high in the next cycle.

## Test plan
- Reset, then a single store A=0x10, WD=0xAAAA0001 with Busy=0 -> the cycle after acceptance shows WE=1, WA=0x10, WD=0xAAAA0001; after the next edge Empty=1 and WE=0.
- Busy=1, enqueue 5 stores to 0x0,0x4,0x8,0xC,0x10 -> first 4 accepted, StoreReady=0 on the 5th, Count=4; release Busy -> writes retire in order 0x0,0x4,0x8,0xC, one per cycle.
- Busy=1, enqueue 0x20/0x11, 0x24/0x22, 0x20/0x33; LoadA=0x20 -> LoadHit=1, LoadData=0x33; LoadA=0x28 -> LoadHit=0, LoadData=0.
- Full queue plus retire plus StoreValid in the same cycle -> the store is refused, Count goes 4->3, StoreReady=1 next cycle; stream 12 stores with Busy=0 -> pointers wrap, all 12 written in order.
- Head store 0x40/0x55 retiring with LoadA=0x40 in that same cycle -> LoadHit=1, LoadData=0x55; next cycle LoadHit=0.
- Reset asserted with 3 stores pending and StoreValid=1 -> no further writes, Count=0, Empty=1, StoreReady=1 next cycle.
